// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM slot arbiter.
package ram_arb_pkg;

   // Who owns the RAM port for the current PHI2 slot.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      DMA_ACC = 2'd2
   } arb_state_e;

   // Values the RAM port rests at when nobody owns the slot.
   localparam logic IDLE_RAMSEL = 1'b0;
   localparam logic IDLE_NWE    = 1'b1;

   // Default geometry.
   localparam int DEF_AW           = 22;
   localparam int DEF_STARVE_LIMIT = 8;

   // Bits needed to count from 0 up to and including limit.
   function automatic int ctr_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of consecutive slots in which a pending DMA request
// lost arbitration. Clear has priority over increment.
module ram_arb_starve_ctr
   import ram_arb_pkg::*;
#(
   parameter int LIMIT = DEF_STARVE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int W = ctr_width(LIMIT);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins, otherwise step up and stick at the limit.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != LIMIT_V)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit_o = (count_q == LIMIT_V);

endmodule

// File: rtl/ram_slot_arbiter.sv
// Shares the byte-wide SDRAM port between the C64 CPU side and the DMA
// engine, one owner per PHI2 slot. CPU wins by default; a DMA request
// that has lost STARVE_LIMIT slots in a row takes the next one and asks
// the CPU-side logic to stall.
module ram_slot_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic          FCLK,
   input  logic          RESET,
   input  logic          SLOT,
   input  logic          SLOTEND,
   input  logic          CPUSEL,
   input  logic          CPUnWE,
   input  logic [AW-1:0] CPUA,
   input  logic [7:0]    CPUWRD,
   input  logic          DMAREQ,
   input  logic          DMAnWE,
   input  logic [AW-1:0] DMAA,
   input  logic [7:0]    DMAWRD,
   output logic          DMAACK,
   output logic          DMADONE,
   output logic [7:0]    DMARD,
   output logic          STALL,
   output logic          OVERRUN,
   output logic          RAMSEL,
   output logic          nWE,
   output logic [AW-1:0] A,
   output logic [7:0]    WRD,
   input  logic [7:0]    RDD
);

   arb_state_e    state_q,   state_d;
   logic          ramsel_q,  ramsel_d;
   logic          nwe_q,     nwe_d;
   logic [AW-1:0] a_q,       a_d;
   logic [7:0]    wrd_q,     wrd_d;
   logic          dmaack_q,  dmaack_d;
   logic          dmadone_q, dmadone_d;
   logic [7:0]    dmard_q,   dmard_d;
   logic          stall_q,   stall_d;
   logic          overrun_q, overrun_d;

   logic          starve_inc;
   logic          starve_clr;
   logic          starve_at_limit;

   logic          grant_forced;
   logic          grant_cpu;
   logic          grant_dma;

   ram_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk        (FCLK),
      .rst        (RESET),
      .inc_i      (starve_inc),
      .clr_i      (starve_clr),
      .at_limit_o (starve_at_limit)
   );

   // Slot-start priority: a starved DMA first, then the CPU, then DMA.
   always_comb begin
      grant_forced = DMAREQ && starve_at_limit;
      grant_cpu    = !grant_forced && CPUSEL;
      grant_dma    = grant_forced || (!CPUSEL && DMAREQ);
   end

   // Next state and outputs: finish the running slot first, then let a
   // coincident SLOT arbitrate so back-to-back slots leave no gap.
   always_comb begin
      state_d    = state_q;
      ramsel_d   = ramsel_q;
      nwe_d      = nwe_q;
      a_d        = a_q;
      wrd_d      = wrd_q;
      dmaack_d   = 1'b0;
      dmadone_d  = 1'b0;
      dmard_d    = dmard_q;
      stall_d    = stall_q;
      overrun_d  = overrun_q;
      starve_inc = 1'b0;
      starve_clr = 1'b0;

      // Slot completion. nwe_q still holds the DMA direction here.
      if (SLOTEND) begin
         case (state_q)
            CPU_ACC: begin
               state_d  = IDLE;
               ramsel_d = IDLE_RAMSEL;
               nwe_d    = IDLE_NWE;
               a_d      = '0;
               wrd_d    = '0;
            end
            DMA_ACC: begin
               state_d   = IDLE;
               ramsel_d  = IDLE_RAMSEL;
               nwe_d     = IDLE_NWE;
               a_d       = '0;
               wrd_d     = '0;
               dmadone_d = 1'b1;
               stall_d   = 1'b0;
               if (nwe_q) begin
                  dmard_d = RDD;
               end
            end
            default: begin
            end
         endcase
      end

      // Slot start. An owner still present without SLOTEND is an overrun;
      // its access is dropped silently and arbitration proceeds as usual.
      if (SLOT) begin
         if ((state_q != IDLE) && !SLOTEND) begin
            overrun_d = 1'b1;
         end

         state_d  = IDLE;
         ramsel_d = IDLE_RAMSEL;
         nwe_d    = IDLE_NWE;
         a_d      = '0;
         wrd_d    = '0;
         stall_d  = 1'b0;

         if (grant_dma) begin
            state_d  = DMA_ACC;
            ramsel_d = 1'b1;
            nwe_d    = DMAnWE;
            a_d      = DMAA;
            wrd_d    = DMAWRD;
            dmaack_d = 1'b1;
            stall_d  = grant_forced;
         end else if (grant_cpu) begin
            state_d  = CPU_ACC;
            ramsel_d = 1'b1;
            nwe_d    = CPUnWE;
            a_d      = CPUA;
            wrd_d    = CPUWRD;
         end

         // Only a pending request that loses a slot counts as starvation.
         if (DMAREQ && !grant_dma) begin
            starve_inc = 1'b1;
         end else begin
            starve_clr = 1'b1;
         end
      end
   end

   // State and registered RAM-port / DMA-side outputs.
   always_ff @(posedge FCLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         ramsel_q  <= IDLE_RAMSEL;
         nwe_q     <= IDLE_NWE;
         a_q       <= '0;
         wrd_q     <= '0;
         dmaack_q  <= 1'b0;
         dmadone_q <= 1'b0;
         dmard_q   <= '0;
         stall_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ramsel_q  <= ramsel_d;
         nwe_q     <= nwe_d;
         a_q       <= a_d;
         wrd_q     <= wrd_d;
         dmaack_q  <= dmaack_d;
         dmadone_q <= dmadone_d;
         dmard_q   <= dmard_d;
         stall_q   <= stall_d;
         overrun_q <= overrun_d;
      end
   end

   assign RAMSEL  = ramsel_q;
   assign nWE     = nwe_q;
   assign A       = a_q;
   assign WRD     = wrd_q;
   assign DMAACK  = dmaack_q;
   assign DMADONE = dmadone_q;
   assign DMARD   = dmard_q;
   assign STALL   = stall_q;
   assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter. Stimulus queues the expected
// output snapshot for every SLOT/SLOTEND edge; a monitor compares it on
// the following falling edge.
module tb_ram_slot_arbiter;

   localparam int AW = 22;

   logic          FCLK    = 1'b0;
   logic          RESET   = 1'b1;
   logic          SLOT    = 1'b0;
   logic          SLOTEND = 1'b0;
   logic          CPUSEL  = 1'b0;
   logic          CPUnWE  = 1'b1;
   logic [AW-1:0] CPUA    = '0;
   logic [7:0]    CPUWRD  = '0;
   logic          DMAREQ  = 1'b0;
   logic          DMAnWE  = 1'b1;
   logic [AW-1:0] DMAA    = '0;
   logic [7:0]    DMAWRD  = '0;
   logic [7:0]    RDD     = '0;
   logic          DMAACK, DMADONE, STALL, OVERRUN, RAMSEL, nWE;
   logic [7:0]    DMARD, WRD;
   logic [AW-1:0] A;

   ram_slot_arbiter #(.AW(AW), .STARVE_LIMIT(8)) dut (
      .FCLK(FCLK), .RESET(RESET), .SLOT(SLOT), .SLOTEND(SLOTEND),
      .CPUSEL(CPUSEL), .CPUnWE(CPUnWE), .CPUA(CPUA), .CPUWRD(CPUWRD),
      .DMAREQ(DMAREQ), .DMAnWE(DMAnWE), .DMAA(DMAA), .DMAWRD(DMAWRD),
      .DMAACK(DMAACK), .DMADONE(DMADONE), .DMARD(DMARD), .STALL(STALL),
      .OVERRUN(OVERRUN), .RAMSEL(RAMSEL), .nWE(nWE), .A(A), .WRD(WRD),
      .RDD(RDD)
   );

   typedef struct packed {
      logic          ramsel;
      logic          nwe;
      logic [AW-1:0] a;
      logic [7:0]    wrd;
      logic          ack;
      logic          done;
      logic [7:0]    rd;
      logic          stall;
      logic          ovr;
   } snap_t;

   snap_t exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  ev_q   = 1'b0;
   snap_t act;
   snap_t mon_e;
   string mon_n;
   logic [7:0] exp_rd;
   logic       exp_ov;

   always #5 FCLK = ~FCLK;

   always_comb act = {RAMSEL, nWE, A, WRD, DMAACK, DMADONE, DMARD, STALL, OVERRUN};

   function automatic snap_t mk(input logic rs, input logic nw, input logic [AW-1:0] a,
                                input logic [7:0] w, input logic ak, input logic dn,
                                input logic [7:0] rd, input logic st, input logic ov);
      return {rs, nw, a, w, ak, dn, rd, st, ov};
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("ramsel=%0b nwe=%0b a=%h wrd=%h ack=%0b done=%0b rd=%h stall=%0b ovr=%0b",
                       s.ramsel, s.nwe, s.a, s.wrd, s.ack, s.done, s.rd, s.stall, s.ovr);
   endfunction

   // Remember whether the last rising edge carried a slot event.
   always @(posedge FCLK) ev_q <= SLOT | SLOTEND;

   // Monitor: compare after each slot event, otherwise pulses must be low.
   always @(negedge FCLK) begin
      if (!RESET) begin
         checks++;
         if (ev_q) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event act %s", fmt(act));
            end else begin
               mon_e = exp_q.pop_front();
               mon_n = name_q.pop_front();
               if (act !== mon_e) begin
                  errors++;
                  $display("FAIL %s act %s req %s", mon_n, fmt(act), fmt(mon_e));
               end else begin
                  $display("ok   %s %s", mon_n, fmt(act));
               end
            end
         end else if (DMAACK !== 1'b0 || DMADONE !== 1'b0) begin
            errors++;
            $display("FAIL stray_pulse act ack=%0b done=%0b req ack=0 done=0", DMAACK, DMADONE);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a_v, input logic [31:0] e_v);
      checks++;
      if (a_v !== e_v) begin
         errors++;
         $display("FAIL %s act=%h req=%h", nm, a_v, e_v);
      end else begin
         $display("ok   %s = %h", nm, a_v);
      end
   endtask

   task automatic step(input logic s, input logic e, input logic push, input snap_t x, input string nm);
      SLOT    = s;
      SLOTEND = e;
      if (push) begin
         exp_q.push_back(x);
         name_q.push_back(nm);
      end
      @(posedge FCLK);
      #1;
      SLOT    = 1'b0;
      SLOTEND = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge FCLK);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_rd = 8'h00;
      exp_ov = 1'b0;

      // Reset values.
      idle(2);
      @(negedge FCLK);
      chk("rst_ramsel", 32'(RAMSEL), 32'd0);
      chk("rst_nwe", 32'(nWE), 32'd1);
      chk("rst_a", 32'(A), 32'd0);
      chk("rst_wrd", 32'(WRD), 32'd0);
      chk("rst_pulses", {30'd0, DMAACK, DMADONE}, 32'd0);
      chk("rst_dmard", 32'(DMARD), 32'd0);
      chk("rst_stall_ovr", {30'd0, STALL, OVERRUN}, 32'd0);
      chk("rst_count", 32'(dut.u_starve.count_q), 32'd0);
      @(posedge FCLK);
      #1;
      RESET = 1'b0;
      idle(1);

      // CPU write; outputs hold even after the CPU inputs change.
      CPUSEL = 1'b1; CPUnWE = 1'b0; CPUA = 22'h12345; CPUWRD = 8'hA5; DMAREQ = 1'b0;
      step(1'b1, 1'b0, 1'b1, mk(1, 0, 22'h12345, 8'hA5, 0, 0, exp_rd, 0, exp_ov), "cpu_wr");
      CPUSEL = 1'b0; CPUA = 22'h0; CPUWRD = 8'h00;
      @(negedge FCLK);
      chk("cpu_hold_a", 32'(A), 32'h12345);
      @(posedge FCLK);
      #1;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "cpu_end");

      // DMA read at top address, request dropped mid-slot.
      DMAREQ = 1'b1; DMAnWE = 1'b1; DMAA = 22'h3FFFFF; DMAWRD = 8'h00;
      step(1'b1, 1'b0, 1'b1, mk(1, 1, 22'h3FFFFF, 8'h00, 1, 0, exp_rd, 0, exp_ov), "dma_rd_grant");
      DMAREQ = 1'b0;
      idle(2);
      RDD = 8'h5A; exp_rd = 8'h5A;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 1, exp_rd, 0, exp_ov), "dma_rd_done");
      RDD = 8'h00;

      // DMA write: DMARD keeps the earlier read value.
      DMAREQ = 1'b1; DMAnWE = 1'b0; DMAA = 22'h000001; DMAWRD = 8'h3C;
      step(1'b1, 1'b0, 1'b1, mk(1, 0, 22'h000001, 8'h3C, 1, 0, exp_rd, 0, exp_ov), "dma_wr_grant");
      idle(1);
      RDD = 8'hFF;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 1, exp_rd, 0, exp_ov), "dma_wr_done");
      DMAREQ = 1'b0; RDD = 8'h00;

      // Starvation: CPU takes 8 slots, the 9th is forced to DMA.
      DMAREQ = 1'b1; DMAnWE = 1'b0; DMAA = 22'h2AAAA; DMAWRD = 8'h77;
      CPUSEL = 1'b1; CPUnWE = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         CPUA = AW'(i); CPUWRD = 8'(8'h10 + i);
         step(1'b1, 1'b0, 1'b1, mk(1, 1, AW'(i), 8'(8'h10 + i), 0, 0, exp_rd, 0, exp_ov), "starve_cpu");
         step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "starve_cpu_end");
      end
      chk("count_at_limit", 32'(dut.u_starve.count_q), 32'd8);
      CPUA = 22'h000100; CPUWRD = 8'hEE;
      step(1'b1, 1'b0, 1'b1, mk(1, 0, 22'h2AAAA, 8'h77, 1, 0, exp_rd, 1, exp_ov), "forced_dma");
      chk("count_after_force", 32'(dut.u_starve.count_q), 32'd0);
      @(negedge FCLK);
      chk("stall_hold", 32'(STALL), 32'd1);
      @(posedge FCLK);
      #1;
      RDD = 8'h42;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 1, exp_rd, 0, exp_ov), "forced_done");
      RDD = 8'h00;
      CPUA = 22'h000200; CPUWRD = 8'h01;
      step(1'b1, 1'b0, 1'b1, mk(1, 1, 22'h000200, 8'h01, 0, 0, exp_rd, 0, exp_ov), "post_force_cpu");
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "post_force_end");

      // Coincident SLOTEND+SLOT: DMA read completes, CPU write starts.
      CPUSEL = 1'b0; DMAnWE = 1'b1; DMAA = 22'h000155;
      step(1'b1, 1'b0, 1'b1, mk(1, 1, 22'h000155, 8'h77, 1, 0, exp_rd, 0, exp_ov), "co_dma");
      idle(1);
      CPUSEL = 1'b1; CPUnWE = 1'b0; CPUA = 22'h0ABCD; CPUWRD = 8'h99; RDD = 8'hC3; exp_rd = 8'hC3;
      step(1'b1, 1'b1, 1'b1, mk(1, 0, 22'h0ABCD, 8'h99, 0, 1, exp_rd, 0, exp_ov), "co_cpu_done");
      DMAREQ = 1'b0; CPUSEL = 1'b0; RDD = 8'h00;
      idle(1);
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "co_end");

      // Overrun: second SLOT with no SLOTEND abandons and regrants DMA.
      DMAREQ = 1'b1; DMAnWE = 1'b1; DMAA = 22'h00FF0; DMAWRD = 8'h00;
      step(1'b1, 1'b0, 1'b1, mk(1, 1, 22'h00FF0, 8'h00, 1, 0, exp_rd, 0, exp_ov), "ovr_grant1");
      idle(1);
      exp_ov = 1'b1;
      step(1'b1, 1'b0, 1'b1, mk(1, 1, 22'h00FF0, 8'h00, 1, 0, exp_rd, 0, exp_ov), "ovr_regrant");
      idle(1);
      RDD = 8'h11; exp_rd = 8'h11;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 1, exp_rd, 0, exp_ov), "ovr_done");
      DMAREQ = 1'b0; RDD = 8'h00;
      CPUSEL = 1'b1; CPUnWE = 1'b1; CPUA = 22'h3FFFFF; CPUWRD = 8'hFF;
      step(1'b1, 1'b0, 1'b1, mk(1, 1, 22'h3FFFFF, 8'hFF, 0, 0, exp_rd, 0, exp_ov), "ovr_sticky");
      CPUSEL = 1'b0;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "ovr_sticky_end");
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "end_in_idle");

      // Reset in the middle of a DMA read: everything drops at once.
      DMAREQ = 1'b1; DMAnWE = 1'b1; DMAA = 22'h000003;
      step(1'b1, 1'b0, 1'b0, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "unused");
      chk("pre_rst_ack", 32'(DMAACK), 32'd1);
      RESET = 1'b1;
      #1;
      chk("mid_rst_ramsel", 32'(RAMSEL), 32'd0);
      chk("mid_rst_pulses", {30'd0, DMAACK, DMADONE}, 32'd0);
      chk("mid_rst_ovr_stall", {30'd0, OVERRUN, STALL}, 32'd0);
      chk("mid_rst_count", 32'(dut.u_starve.count_q), 32'd0);
      @(posedge FCLK);
      #1;
      RESET = 1'b0; DMAREQ = 1'b0; exp_rd = 8'h00; exp_ov = 1'b0;
      idle(1);
      RDD = 8'hAB;
      step(1'b0, 1'b1, 1'b1, mk(0, 1, 22'h0, 8'h00, 0, 0, exp_rd, 0, exp_ov), "post_rst_end");
      RDD = 8'h00;

      idle(2);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_slot_arbiter.md
Name: ram_slot_arbiter

Overview:
- Shares the single-byte SDRAM access port (RAMSEL/nWE/A/WRD/RDD) between the C64 CPU side and an on-card DMA engine.
- Grants at most one requester per PHI2 slot and latches that requester's address, data and direction into registered RAM-port outputs for the slot's duration.
- Captures read data for the DMA side at slot end.
- CPU has priority; a starvation guard forces a DMA slot and signals the CPU-side logic to stall.

Parameters:
- AW, 22, RAM address width.
- STARVE_LIMIT, 8, consecutive denied DMA slots before a DMA slot is forced.

Ports:
- FCLK  in  1  fast clock, the same domain as the SDRAM controller.
- RESET  in  1  asynchronous, active-high reset.
- SLOT  in  1  one-FCLK pulse at PHI2 slot start; arbitration happens here.
- SLOTEND  in  1  one-FCLK pulse when RDD is valid for the current slot.
- CPUSEL  in  1  CPU requests RAM this slot.
- CPUnWE  in  1  CPU direction, 0 = write.
- CPUA  in  AW  CPU address.
- CPUWRD  in  8  CPU write data.
- DMAREQ  in  1  DMA request; held with DMAA/DMAWRD/DMAnWE stable until DMADONE.
- DMAnWE  in  1  DMA direction, 0 = write.
- DMAA  in  AW  DMA address.
- DMAWRD  in  8  DMA write data.
- DMAACK  out  1  one-cycle pulse when DMA is granted a slot.
- DMADONE  out  1  one-cycle pulse when the DMA access completes.
- DMARD  out  8  DMA read data, valid from DMADONE until the next DMADONE.
- STALL  out  1  high for a forced-DMA slot; CPU-side logic holds the CPU off.
- OVERRUN  out  1  sticky flag: SLOT arrived before SLOTEND; cleared only by RESET.
- RAMSEL  out  1  to the RAM controller.
- nWE  out  1  to the RAM controller.
- A  out  AW  to the RAM controller.
- WRD  out  8  to the RAM controller.
- RDD  in  8  read data from the RAM controller.

Behaviour:
- Reset: all outputs go to their reset values asynchronously and state = IDLE.
  - RAMSEL=0, nWE=1, A=0, WRD=0.
  - DMAACK=0, DMADONE=0, DMARD=0, STALL=0, OVERRUN=0.
  - Starve count=0.
- States: IDLE, CPU_ACC, DMA_ACC.
- Arbitration happens on the FCLK edge where SLOT=1, with the slot's requester sampled in that cycle. Priority order:
  - DMAREQ and count==STARVE_LIMIT → DMA_ACC, STALL=1.
  - else CPUSEL → CPU_ACC.
  - else DMAREQ → DMA_ACC.
  - else IDLE.
- Latency: RAMSEL/nWE/A/WRD are registered and valid on the edge after the SLOT cycle. They are held constant until slot end.
  - CPU_ACC drives CPUA/CPUWRD/CPUnWE.
  - DMA_ACC drives DMAA/DMAWRD/DMAnWE.
  - IDLE drives the reset values.
- DMAACK pulses in the same cycle the DMA_ACC registers load.
- SLOTEND in CPU_ACC → IDLE, RAM outputs return to idle values.
- SLOTEND in DMA_ACC → IDLE.
  - DMARD <= RDD for reads; DMARD is unchanged for writes.
  - DMADONE pulses one cycle later, together with the updated DMARD.
  - STALL clears.
- SLOTEND in IDLE: ignored.
- SLOT and SLOTEND in the same cycle: SLOTEND is processed first (completion, DMADONE), then SLOT arbitrates. No idle cycle is inserted.
- SLOT in CPU_ACC/DMA_ACC without SLOTEND:
  - OVERRUN is set.
  - The current access is abandoned with no DMADONE, then SLOT arbitrates normally.
  - DMA retries naturally because DMAREQ is still high.
- Starve counter, updated on each SLOT:
  - DMAREQ=1 and DMA not granted → count+1, saturating at STARVE_LIMIT.
  - DMA granted or DMAREQ=0 → count=0.
  - Width is clog2(STARVE_LIMIT+1).
- DMAREQ deasserted mid-slot after grant: the access still completes and DMADONE still pulses.
- Mid-operation RESET: access aborted immediately; no DONE is issued.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum (IDLE/CPU_ACC/DMA_ACC);
  - idle RAM-port constants (nWE=1, RAMSEL=0);
  - the default STARVE_LIMIT.
- One natural sub-module: ram_arb_starve_ctr, a saturating counter with inc/clr/at_limit.

Test Plan:
- CPUSEL=1 write, CPUA=0x12345, CPUWRD=0xA5 at SLOT → next edge RAMSEL=1, nWE=0, A=0x12345, WRD=0xA5; idle after SLOTEND.
- DMAREQ=1 read, DMAA=0x3FFFFF, CPUSEL=0, RDD=0x5A at SLOTEND → DMAACK 1 cycle after SLOT; DMADONE plus DMARD=0x5A one cycle after SLOTEND.
- CPUSEL=1 and DMAREQ=1 for 9 slots (STARVE_LIMIT=8) → CPU wins slots 1-8; slot 9 grants DMA with STALL=1; counter resets to 0.
- SLOTEND and SLOT coincident with DMA completing and CPU requesting → DMADONE pulses and CPU_ACC entered with no gap.
- SLOT twice without SLOTEND during a DMA read → OVERRUN=1 sticky, no DMADONE, DMAACK re-pulses on regrant.
- RESET asserted mid-DMA_ACC → RAMSEL=0 and DMAACK/DMADONE=0 immediately, starve count=0.
